// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS datapath constants and load-type encodings
// Purpose: constants and enums shared by the MEM/WB stage and its load extractor.
// Ports: none (package).
package mips_pkg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;

    typedef enum logic [2:0] {
        LT_LW  = 3'd0,
        LT_LH  = 3'd1,
        LT_LHU = 3'd2,
        LT_LB  = 3'd3,
        LT_LBU = 3'd4
    } load_type_e;

endpackage

// File: rtl/load_extractor.sv
// rtl/load_extractor.sv - byte/half/word load extraction with sign/zero extension
// Purpose: picks the addressed byte or halfword out of an aligned little-endian
//          word and flags accesses that are not naturally aligned.
// Ports:
//   word       in   aligned 32-bit word from data memory
//   offset     in   byte offset within the word (address bits [1:0])
//   load_type  in   load encoding (LW/LH/LHU/LB/LBU); other values act as LW
//   data       out  extended load result
//   misaligned out  access not aligned to its size
module load_extractor
    import mips_pkg::*;
(
    input  logic [DATA_W-1:0] word,
    input  logic [1:0]        offset,
    input  logic [2:0]        load_type,
    output logic [DATA_W-1:0] data,
    output logic              misaligned
);

    logic [15:0] half_sel;
    logic [7:0]  byte_sel;

    always_comb begin
        // Halfword selection uses only offset[1]; offset[0] only matters for misalignment.
        half_sel = offset[1] ? word[31:16] : word[15:0];
        case (offset)
            2'd0:    byte_sel = word[7:0];
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            default: byte_sel = word[31:24];
        endcase
    end

    always_comb begin
        data       = word;
        misaligned = (offset != 2'd0);
        case (load_type)
            LT_LH: begin
                data       = {{16{half_sel[15]}}, half_sel};
                misaligned = offset[0];
            end
            LT_LHU: begin
                data       = {16'h0000, half_sel};
                misaligned = offset[0];
            end
            LT_LB: begin
                data       = {{24{byte_sel[7]}}, byte_sel};
                misaligned = 1'b0;
            end
            LT_LBU: begin
                data       = {24'h000000, byte_sel};
                misaligned = 1'b0;
            end
            default: begin
                data       = word;
                misaligned = (offset != 2'd0);
            end
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM/WB pipeline register and register-bank writeback
// Purpose: registers the MEM-stage result, selects link/load/ALU write data,
//          drives the register-bank write port, flags misaligned loads and
//          counts retired instructions.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   stall, flush                hold / bubble the WB register (flush wins)
//   mem_*                       MEM-stage instruction fields
//   wb_valid, wb_reg_write,
//   wb_write_reg, wb_write_data register-bank write port
//   misaligned_load, err_sticky misaligned load in WB / seen since reset
//   retire_count                retired instruction count (wraps)
module mem_wb_stage #(
    parameter int DATA_W     = mips_pkg::DATA_W,
    parameter int REG_ADDR_W = mips_pkg::REG_ADDR_W,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  mem_valid,
    input  logic                  mem_reg_write,
    input  logic [REG_ADDR_W-1:0] mem_write_reg,
    input  logic                  mem_to_reg,
    input  logic                  mem_link,
    input  logic [2:0]            mem_load_type,
    input  logic [DATA_W-1:0]     mem_alu_result,
    input  logic [DATA_W-1:0]     mem_read_data,
    input  logic [DATA_W-1:0]     mem_pc_plus4,
    output logic                  wb_valid,
    output logic                  wb_reg_write,
    output logic [REG_ADDR_W-1:0] wb_write_reg,
    output logic [DATA_W-1:0]     wb_write_data,
    output logic                  misaligned_load,
    output logic                  err_sticky,
    output logic [CNT_W-1:0]      retire_count
);

    logic                  valid_q,     valid_d;
    logic                  reg_write_q, reg_write_d;
    logic [REG_ADDR_W-1:0] write_reg_q, write_reg_d;
    logic                  to_reg_q,    to_reg_d;
    logic                  link_q,      link_d;
    logic [2:0]            load_type_q, load_type_d;
    logic [DATA_W-1:0]     alu_q,       alu_d;
    logic [DATA_W-1:0]     rdata_q,     rdata_d;
    logic [DATA_W-1:0]     pc4_q,       pc4_d;
    logic                  err_q,       err_d;
    logic [CNT_W-1:0]      cnt_q,       cnt_d;

    logic [DATA_W-1:0]     load_data;
    logic                  load_mis;
    logic                  retire;

    load_extractor u_load_extractor (
        .word       (rdata_q),
        .offset     (alu_q[1:0]),
        .load_type  (load_type_q),
        .data       (load_data),
        .misaligned (load_mis)
    );

    assign misaligned_load = valid_q & to_reg_q & load_mis;
    assign wb_valid        = valid_q;
    assign wb_write_reg    = write_reg_q;
    assign wb_reg_write    = valid_q & reg_write_q & (write_reg_q != '0) & ~misaligned_load;
    assign wb_write_data   = link_q   ? pc4_q     :
                             to_reg_q ? load_data : alu_q;
    assign err_sticky      = err_q;
    assign retire_count    = cnt_q;

    // An entry leaves WB when it is not held; a flush also pushes it out even if stalled.
    assign retire = valid_q & (~stall | flush);

    always_comb begin
        valid_d     = valid_q;
        reg_write_d = reg_write_q;
        write_reg_d = write_reg_q;
        to_reg_d    = to_reg_q;
        link_d      = link_q;
        load_type_d = load_type_q;
        alu_d       = alu_q;
        rdata_d     = rdata_q;
        pc4_d       = pc4_q;
        if (flush) begin
            valid_d     = 1'b0;
            reg_write_d = 1'b0;
        end else if (!stall) begin
            valid_d     = mem_valid;
            reg_write_d = mem_valid & mem_reg_write;
            write_reg_d = mem_write_reg;
            to_reg_d    = mem_to_reg;
            link_d      = mem_link;
            load_type_d = mem_load_type;
            alu_d       = mem_alu_result;
            rdata_d     = mem_read_data;
            pc4_d       = mem_pc_plus4;
        end
        err_d = err_q | misaligned_load;
        cnt_d = cnt_q + CNT_W'(retire);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            write_reg_q <= '0;
            to_reg_q    <= 1'b0;
            link_q      <= 1'b0;
            load_type_q <= '0;
            alu_q       <= '0;
            rdata_q     <= '0;
            pc4_q       <= '0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            valid_q     <= valid_d;
            reg_write_q <= reg_write_d;
            write_reg_q <= write_reg_d;
            to_reg_q    <= to_reg_d;
            link_q      <= link_d;
            load_type_q <= load_type_d;
            alu_q       <= alu_d;
            rdata_q     <= rdata_d;
            pc4_q       <= pc4_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - self-checking bench for mem_wb_stage
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        mem_valid;
    logic        mem_reg_write;
    logic [4:0]  mem_write_reg;
    logic        mem_to_reg;
    logic        mem_link;
    logic [2:0]  mem_load_type;
    logic [31:0] mem_alu_result;
    logic [31:0] mem_read_data;
    logic [31:0] mem_pc_plus4;
    logic        wb_valid;
    logic        wb_reg_write;
    logic [4:0]  wb_write_reg;
    logic [31:0] wb_write_data;
    logic        misaligned_load;
    logic        err_sticky;
    logic [31:0] retire_count;

    always #5 clk = ~clk;

    mem_wb_stage dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .flush           (flush),
        .mem_valid       (mem_valid),
        .mem_reg_write   (mem_reg_write),
        .mem_write_reg   (mem_write_reg),
        .mem_to_reg      (mem_to_reg),
        .mem_link        (mem_link),
        .mem_load_type   (mem_load_type),
        .mem_alu_result  (mem_alu_result),
        .mem_read_data   (mem_read_data),
        .mem_pc_plus4    (mem_pc_plus4),
        .wb_valid        (wb_valid),
        .wb_reg_write    (wb_reg_write),
        .wb_write_reg    (wb_write_reg),
        .wb_write_data   (wb_write_data),
        .misaligned_load (misaligned_load),
        .err_sticky      (err_sticky),
        .retire_count    (retire_count)
    );

    typedef struct {
        logic        v;
        logic        rw;
        logic [4:0]  wr;
        logic        tr;
        logic        lk;
        logic [2:0]  lt;
        logic [31:0] alu;
        logic [31:0] rd;
        logic [31:0] pc;
        logic        ewe;
        logic [31:0] edata;
        logic        emis;
    } vec_t;

    vec_t        vecs[$];
    vec_t        sb[$];
    vec_t        cur;
    vec_t        prev;
    int          n_pass = 0;
    int          n_total = 0;
    logic [31:0] exp_cnt;
    logic        exp_err;
    logic [31:0] cnt0;

    localparam logic [31:0] W = 32'h80FF7F01;

    function automatic vec_t mk(logic v, logic rw, logic [4:0] wr, logic tr, logic lk,
                                logic [2:0] lt, logic [31:0] alu, logic [31:0] rd,
                                logic [31:0] pc, logic ewe, logic [31:0] edata, logic emis);
        vec_t r;
        r.v = v; r.rw = rw; r.wr = wr; r.tr = tr; r.lk = lk; r.lt = lt;
        r.alu = alu; r.rd = rd; r.pc = pc; r.ewe = ewe; r.edata = edata; r.emis = emis;
        return r;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        else
            n_pass++;
    endtask

    task automatic drive(vec_t v);
        mem_valid      = v.v;
        mem_reg_write  = v.rw;
        mem_write_reg  = v.wr;
        mem_to_reg     = v.tr;
        mem_link       = v.lk;
        mem_load_type  = v.lt;
        mem_alu_result = v.alu;
        mem_read_data  = v.rd;
        mem_pc_plus4   = v.pc;
    endtask

    task automatic drive_random();
        mem_valid      = 1'($urandom);
        mem_reg_write  = 1'($urandom);
        mem_write_reg  = 5'($urandom);
        mem_to_reg     = 1'($urandom);
        mem_link       = 1'($urandom);
        mem_load_type  = 3'($urandom);
        mem_alu_result = $urandom;
        mem_read_data  = $urandom;
        mem_pc_plus4   = $urandom;
    endtask

    initial begin
        // ALU op, loads across offsets, misaligned loads, link, $0, bubble, undefined types
        vecs.push_back(mk(1,1,5'd5, 0,0,3'd0,32'hDEADBEEF,32'h0,      32'h0,       1,32'hDEADBEEF,0));
        vecs.push_back(mk(1,1,5'd3, 1,0,3'd3,32'h00001000,W,          32'h0,       1,32'h00000001,0));
        vecs.push_back(mk(1,1,5'd3, 1,0,3'd3,32'h00001001,W,          32'h0,       1,32'h0000007F,0));
        vecs.push_back(mk(1,1,5'd3, 1,0,3'd3,32'h00001002,W,          32'h0,       1,32'hFFFFFFFF,0));
        vecs.push_back(mk(1,1,5'd3, 1,0,3'd3,32'h00001003,W,          32'h0,       1,32'hFFFFFF80,0));
        vecs.push_back(mk(1,1,5'd4, 1,0,3'd4,32'h00001003,W,          32'h0,       1,32'h00000080,0));
        vecs.push_back(mk(1,1,5'd4, 1,0,3'd4,32'h00001001,W,          32'h0,       1,32'h0000007F,0));
        vecs.push_back(mk(1,1,5'd6, 1,0,3'd1,32'h00001002,W,          32'h0,       1,32'hFFFF80FF,0));
        vecs.push_back(mk(1,1,5'd6, 1,0,3'd2,32'h00001002,W,          32'h0,       1,32'h000080FF,0));
        vecs.push_back(mk(1,1,5'd8, 1,0,3'd0,32'h00001000,W,          32'h0,       1,W,           0));
        vecs.push_back(mk(1,1,5'd6, 1,0,3'd1,32'h00001001,W,          32'h0,       0,32'h00007F01,1));
        vecs.push_back(mk(1,1,5'd7, 1,0,3'd0,32'h00001002,W,          32'h0,       0,W,           1));
        vecs.push_back(mk(1,1,5'd31,1,1,3'd0,32'h00000000,W,          32'h00400010,1,32'h00400010,0));
        vecs.push_back(mk(1,1,5'd0, 1,1,3'd0,32'h00000000,W,          32'h00400010,0,32'h00400010,0));
        vecs.push_back(mk(0,1,5'd4, 1,0,3'd0,32'h00001002,W,          32'h0,       0,W,           0));
        vecs.push_back(mk(1,1,5'd9, 1,0,3'd7,32'h00001000,W,          32'h0,       1,W,           0));
        vecs.push_back(mk(1,1,5'd9, 1,0,3'd5,32'h00001002,W,          32'h0,       0,W,           1));
        vecs.push_back(mk(1,0,5'd10,0,0,3'd0,32'h00000055,32'h0,      32'h0,       0,32'h00000055,0));

        // Reset with every input toggling
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        drive_random();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i > 0) begin
                chk("rst_valid", 32'(wb_valid), 32'h0);
                chk("rst_we", 32'(wb_reg_write), 32'h0);
                chk("rst_wreg", 32'(wb_write_reg), 32'h0);
                chk("rst_wdata", wb_write_data, 32'h0);
                chk("rst_mis", 32'(misaligned_load), 32'h0);
                chk("rst_err", 32'(err_sticky), 32'h0);
                chk("rst_cnt", retire_count, 32'h0);
            end
            drive_random();
            stall = 1'($urandom);
            flush = 1'($urandom);
        end

        // Table-driven phase: scoreboard holds the expectation for the entry in flight
        reset = 1'b0; stall = 1'b0; flush = 1'b0;
        exp_cnt = 32'h0; exp_err = 1'b0;
        prev = mk(0,0,5'd0,0,0,3'd0,32'h0,32'h0,32'h0,0,32'h0,0);
        for (int i = 0; i <= vecs.size(); i++) begin
            if (i > 0) begin
                @(negedge clk);
                if (sb.size() != 0) begin
                    cur = sb.pop_front();
                    exp_cnt = exp_cnt + 32'(prev.v);
                    exp_err = exp_err | prev.emis;
                    chk($sformatf("v%0d_valid", i-1), 32'(wb_valid), 32'(cur.v));
                    chk($sformatf("v%0d_we", i-1), 32'(wb_reg_write), 32'(cur.ewe));
                    chk($sformatf("v%0d_wreg", i-1), 32'(wb_write_reg), 32'(cur.wr));
                    chk($sformatf("v%0d_wdata", i-1), wb_write_data, cur.edata);
                    chk($sformatf("v%0d_mis", i-1), 32'(misaligned_load), 32'(cur.emis));
                    chk($sformatf("v%0d_err", i-1), 32'(err_sticky), 32'(exp_err));
                    chk($sformatf("v%0d_cnt", i-1), retire_count, exp_cnt);
                    prev = cur;
                end else begin
                    chk("sb_underflow", 32'h1, 32'(sb.size()));
                end
            end
            if (i < vecs.size()) begin
                drive(vecs[i]);
                sb.push_back(vecs[i]);
            end
        end

        // Stall holds a valid entry for 3 cycles, then stall+flush retires it
        drive(mk(1,1,5'd9,0,0,3'd0,32'h12345678,32'h0,32'h0,1,32'h12345678,0));
        @(negedge clk);
        exp_cnt = exp_cnt + 32'(prev.v);
        chk("stl_load_wdata", wb_write_data, 32'h12345678);
        chk("stl_load_cnt", retire_count, exp_cnt);
        cnt0 = exp_cnt;
        stall = 1'b1;
        drive(mk(1,1,5'd3,0,0,3'd0,32'hFFFF0000,32'h0,32'h0,0,32'h0,0));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stl_hold_we", 32'(wb_reg_write), 32'h1);
            chk("stl_hold_wreg", 32'(wb_write_reg), 32'd9);
            chk("stl_hold_wdata", wb_write_data, 32'h12345678);
            chk("stl_hold_cnt", retire_count, cnt0);
        end
        flush = 1'b1;
        @(negedge clk);
        chk("stlflush_valid", 32'(wb_valid), 32'h0);
        chk("stlflush_cnt", retire_count, cnt0 + 32'd1);
        stall = 1'b0; flush = 1'b0;

        // Misaligned load held under stall keeps the flag up
        drive(mk(1,1,5'd7,1,0,3'd0,32'h00002002,W,32'h0,0,W,1));
        @(negedge clk);
        chk("mstl_mis0", 32'(misaligned_load), 32'h1);
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("mstl_mis", 32'(misaligned_load), 32'h1);
            chk("mstl_we", 32'(wb_reg_write), 32'h0);
        end
        stall = 1'b0;
        drive(mk(0,0,5'd0,0,0,3'd0,32'h0,32'h0,32'h0,0,32'h0,0));
        @(negedge clk);
        chk("mstl_clear", 32'(misaligned_load), 32'h0);
        chk("mstl_cnt", retire_count, cnt0 + 32'd2);
        chk("mstl_err", 32'(err_sticky), 32'h1);

        // Counter wrap from all-ones
        drive(mk(1,1,5'd2,0,0,3'd0,32'h00000055,32'h0,32'h0,1,32'h00000055,0));
        @(negedge clk);
        force dut.cnt_q = 32'hFFFFFFFF;
        #1;
        release dut.cnt_q;
        drive(mk(0,0,5'd0,0,0,3'd0,32'h0,32'h0,32'h0,0,32'h0,0));
        @(negedge clk);
        chk("wrap_cnt", retire_count, 32'h0);

        // Reset clears the sticky error and counter
        reset = 1'b1; stall = 1'b1; flush = 1'b1;
        @(negedge clk);
        chk("rst2_err", 32'(err_sticky), 32'h0);
        chk("rst2_cnt", retire_count, 32'h0);
        chk("rst2_valid", 32'(wb_valid), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- MEM/WB pipeline register plus writeback logic for the pipelined MIPS core.
- Captures memory-stage results and extracts or sign-extends load data for byte, half and word loads.
- Selects among ALU result, load data and link address, and drives the write port of the register bank.
- Also flags misaligned loads and counts retired instructions.

Parameters:
DATA_W, 32, datapath width
REG_ADDR_W, 5, register address width
CNT_W, 32, retire counter width

Ports:
clk  input  1  core clock
reset  input  1  synchronous, active-high reset
stall  input  1  hold WB register contents
flush  input  1  replace incoming entry with a bubble
mem_valid  input  1  MEM stage holds a real instruction
mem_reg_write  input  1  instruction writes a register
mem_write_reg  input  REG_ADDR_W  destination register
mem_to_reg  input  1  result comes from load data
mem_link  input  1  result is pc_plus4 (jal/jalr); has priority over mem_to_reg
mem_load_type  input  3  load encoding: LW, LH, LHU, LB, LBU
mem_alu_result  input  DATA_W  ALU result; bits [1:0] give the load byte offset
mem_read_data  input  DATA_W  raw aligned word from data memory, little-endian
mem_pc_plus4  input  DATA_W  link address
wb_valid  output  1  WB register holds a real instruction
wb_reg_write  output  1  write enable to the register bank
wb_write_reg  output  REG_ADDR_W  write address to the register bank
wb_write_data  output  DATA_W  write data to the register bank
misaligned_load  output  1  misaligned load currently in WB
err_sticky  output  1  a misaligned load has been seen since reset
retire_count  output  CNT_W  count of retired instructions

Behaviour:
- Reset (posedge clk with reset=1):
  - All WB register fields clear.
  - wb_valid=0, wb_reg_write=0, wb_write_reg=0, wb_write_data=0.
  - misaligned_load=0, err_sticky=0, retire_count=0.
  - Reset mid-stall or mid-flush still wins.
- Latency: one cycle. MEM inputs sampled at posedge N appear on the wb_* outputs after posedge N, combinationally derived from the registered fields.
- Per-posedge update priority is reset > flush > stall > load:
  - flush: register becomes a bubble (valid=0, reg_write=0, other fields don't-care).
  - stall: all fields hold.
  - otherwise: capture the mem_* inputs. If mem_valid=0, capture as a bubble.
- wb_reg_write = valid & reg_write & (write_reg!=0) & !misaligned. Writes to $0 are never issued.
- Write data select: link → pc_plus4; else mem_to_reg → extracted load; else alu_result.
- Load extraction uses registered offset o = alu_result[1:0]:
  - LW: whole word.
  - LH/LHU: halfword at bits [16*o[1]+15 : 16*o[1]]; LH sign-extends, LHU zero-extends.
  - LB/LBU: byte at bits [8*o+7 : 8*o]; LB sign-extends, LBU zero-extends.
- Misalignment:
  - Defined as valid & mem_to_reg & ((LW & o!=0) | ((LH|LHU) & o[0])).
  - misaligned_load follows it combinationally and is held high while the entry is stalled.
  - err_sticky sets at the posedge where misaligned is high and clears only on reset.
- retire_count:
  - Increments at a posedge when wb_valid=1 and stall=0, including misaligned entries.
  - Does not increment under stall.
  - Wraps modulo 2^CNT_W.
- Simultaneous stall and flush: flush wins, and the counter still increments if wb_valid=1.
- Undefined mem_load_type values are treated as LW.

Decomposition:
- Shared package mips_pkg holds the load-type encodings (LW=0, LH=1, LHU=2, LB=3, LBU=4) and the DATA_W / REG_ADDR_W constants.
- One sub-module, load_extractor: combinational; inputs word, offset, type; outputs data and misaligned.

Test Plan:
- Reset with all inputs toggling: outputs stay 0, retire_count=0. Release reset, issue an ALU op writing 0xDEADBEEF to r5: one cycle later wb_reg_write=1, wb_write_reg=5, wb_write_data=0xDEADBEEF, retire_count=1 after the next edge.
- Word 0x80FF7F01 with offsets 0..3: LB gives 0x00000001, 0x0000007F, 0xFFFFFFFF, 0xFFFFFF80; LBU offset 3 gives 0x00000080; LH offset 2 gives 0xFFFF80FF; LHU offset 2 gives 0x000080FF.
- LW offset 2 to r7: wb_reg_write=0, misaligned_load=1 for one cycle, err_sticky=1 afterwards until reset.
- jal with link=1, pc_plus4=0x00400010, write_reg=31, mem_to_reg=1: wb_write_data=0x00400010. Same instruction with write_reg=0: wb_reg_write=0.
- Valid entry held with stall=1 for 3 cycles: outputs constant, retire_count unchanged. Then stall=1 and flush=1 together: wb_valid=0 next cycle and retire_count +1.
- Preload retire_count to all-ones by forcing, then retire one instruction: count wraps to 0.
